// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Round-robin arbiter that lets NUM_REQ byte-stream requesters share one
//   UART transmitter. A requester wins the transmitter for a whole frame,
//   which ends with the byte flagged by req_last. Bytes go through a single
//   output register stage toward the transmitter.
//
//   Optional feature: define UART_ARB_TAG_EN to send one tag byte
//   (TAG_BASE + requester index) ahead of each frame. Without the macro, the
//   TAG state is not compiled and IDLE goes straight to DATA.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   TAG_BASE  tag byte for requester 0; requester i uses TAG_BASE + i
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req_data       byte of requester i on bits [i*8 +: 8]
//   req_valid      requester i offers a byte
//   req_last       offered byte is the final byte of its frame
//   req_ready      byte of requester i is accepted this cycle
//   tx_data        byte to the UART transmitter
//   tx_data_valid  tx_data holds a byte for the transmitter
//   tx_data_ready  transmitter takes tx_data this cycle
//   grant          one-hot owner of the transmitter, zero when idle
//   busy           FSM not idle or a byte is still waiting in tx_data
module uart_tx_arb #(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] TAG_BASE = 8'h30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
`ifdef UART_ARB_TAG_EN
    TAG,
`endif
    DATA
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDXW-1:0]    idx_q;
  logic [IDXW-1:0]    rrPtr_q;
  logic [7:0]         txData_q;
  logic               txValid_q;

  logic [IDXW-1:0]    pickIdx;
  logic [IDXW-1:0]    rrPtr_d;
  logic               slotFree;
  logic               selValid;
  logic               selLast;
  logic [7:0]         selData;
  logic               accept;

  // Round-robin pick: the first pass finds the lowest valid requester
  // overall (the wrap-around case); the second pass overrides it with the
  // lowest valid requester at or above rrPtr_q when one exists. Both loops
  // run downward so the lowest index is written last and wins.
  always_comb begin
    pickIdx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) pickIdx = IDXW'(j);
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (IDXW'(j) >= rrPtr_q)) pickIdx = IDXW'(j);
    end
  end

  // The output register can take a new byte when it is empty or is being
  // drained this very cycle.
  assign slotFree = !txValid_q || tx_data_ready;
  assign selValid = req_valid[idx_q];
  assign selLast  = req_last[idx_q];
  assign selData  = req_data[{idx_q, 3'b000} +: 8];
  assign accept   = (state_q == DATA) && grant_q[idx_q] && selValid && slotFree;
  assign rrPtr_d  = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Only the granted requester can see ready, and only in DATA.
  always_comb begin
    req_ready        = '0;
    req_ready[idx_q] = accept;
  end

  // Arbitration FSM with the output register. A transfer to the
  // transmitter clears tx_data_valid by default; any load on the same edge
  // overrides that, so back-to-back bytes flow without bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      rrPtr_q   <= '0;
      txData_q  <= 8'h00;
      txValid_q <= 1'b0;
    end else begin
      if (txValid_q && tx_data_ready) txValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
            idx_q   <= pickIdx;
`ifdef UART_ARB_TAG_EN
            state_q <= TAG;
`else
            state_q <= DATA;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG: begin
          if (slotFree) begin
            txData_q  <= TAG_BASE + 8'(idx_q);
            txValid_q <= 1'b1;
            state_q   <= DATA;
          end
        end
`endif
        DATA: begin
          // The grant is held however long the owner stalls; it is only
          // released by accepting the byte flagged last.
          if (accept) begin
            txData_q  <= selData;
            txValid_q <= 1'b1;
            if (selLast) begin
              grant_q <= '0;
              state_q <= IDLE;
              rrPtr_q <= rrPtr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data       = txData_q;
  assign tx_data_valid = txValid_q;
  assign grant         = grant_q;
  assign busy          = (state_q != IDLE) || txValid_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
//   Scoreboard bench for uart_tx_arb (NUM_REQ = 4, TAG_BASE = 8'h30).
//   Expected transmitter bytes are queued when a frame is launched and
//   popped by a monitor whenever the DUT hands a byte to the transmitter.
//   Tag bytes are expected only when UART_ARB_TAG_EN is defined.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ-1:0]   reqLast;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_data_valid;
  logic              tx_data_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;

  logic [7:0] reqData [NREQ];
  logic [7:0] frameBuf [NREQ][16];
  int         frameLen [NREQ];
  logic [7:0] sb [$];

  int   vectors     = 0;
  int   miscompares = 0;
  bit   stallActive = 1'b0;
  bit   streamDone  = 1'b0;
  bit   prevHold    = 1'b0;
  logic [7:0] heldData = 8'h00;

  uart_tx_arb #(.NUM_REQ(NREQ), .TAG_BASE(8'h30)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_data      (req_data),
    .req_valid     (reqValid),
    .req_last      (reqLast),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .grant         (grant),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = reqData[i];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushFrame(input int r);
    if (TAG_ON) sb.push_back(8'h30 + 8'(r));
    for (int b = 0; b < frameLen[r]; b++) sb.push_back(frameBuf[r][b]);
  endtask

  // Called at posedge+1 with the byte on the bus; returns at posedge+1
  // after the edge that accepted it.
  task automatic waitAccept(input int r);
    bit got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) checkOutput($sformatf("acceptTimeout%0d", r), 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int r, input int stallAt);
    for (int b = 0; b < frameLen[r]; b++) begin
      if (b == stallAt) begin
        reqValid[r] = 1'b0;
        stallActive = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        stallActive = 1'b0;
      end
      reqData[r]  = frameBuf[r][b];
      reqLast[r]  = (b == frameLen[r] - 1);
      reqValid[r] = 1'b1;
      waitAccept(r);
    end
    reqValid[r] = 1'b0;
    reqLast[r]  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 2000 && sb.size() != 0; c++) @(posedge clk);
    #1;
    if (sb.size() != 0) checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every transmitter handshake, checks that
  // a stalled output byte stays put, and watches the lock during a stall.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prevHold = 1'b0;
      end else begin
        if (prevHold && tx_data_valid) checkOutput("holdStable", 32'(tx_data), 32'(heldData));
        if (tx_data_valid && tx_data_ready) begin
          if (sb.size() == 0) checkOutput("unexpectedByte", 32'(tx_data), 32'hFFFF_FFFF);
          else checkOutput("txByte", 32'(tx_data), 32'(sb.pop_front()));
        end
        prevHold = tx_data_valid && !tx_data_ready;
        heldData = tx_data;
        if (stallActive) begin
          checkOutput("stallGrant", 32'(grant), 32'h2);
          checkOutput("stallReady3", 32'(req_ready[3]), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    rst           = 1'b1;
    reqValid      = '0;
    reqLast       = '0;
    tx_data_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) reqData[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstGrant", 32'(grant), 32'd0);
    checkOutput("rstValid", 32'(tx_data_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstData", 32'(tx_data), 32'd0);
    checkOutput("rstReady", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Requester 2 sends "OK\r\n"; grant appears one cycle after valid
    frameBuf[2][0] = 8'h4F; frameBuf[2][1] = 8'h4B;
    frameBuf[2][2] = 8'h0D; frameBuf[2][3] = 8'h0A;
    frameLen[2] = 4;
    pushFrame(2);
    tx_data_ready = 1'b1;
    fork
      applyStimulus(2, -1);
      begin
        @(negedge clk);
        checkOutput("grantLat0", 32'(grant), 32'd0);
        @(negedge clk);
        checkOutput("grantLat1", 32'(grant), 32'h4);
      end
    join
    @(negedge clk);
    checkOutput("grantEnd", 32'(grant), 32'd0);
    @(posedge clk);
    #1;
    waitDrain();

    // All four send one byte from rr_ptr=0; requester 0 re-requests at once
    resetDut();
    for (int i = 0; i < NREQ; i++) begin
      frameBuf[i][0] = 8'hA0 + 8'(i);
      frameLen[i]    = 1;
      pushFrame(i);
    end
    if (TAG_ON) sb.push_back(8'h30);
    sb.push_back(8'hC0);
    fork
      begin
        applyStimulus(0, -1);
        frameBuf[0][0] = 8'hC0;
        applyStimulus(0, -1);
      end
      applyStimulus(1, -1);
      applyStimulus(2, -1);
      applyStimulus(3, -1);
    join
    waitDrain();

    // Requester 0 streams 15 bytes while the transmitter is ready 1 in 10
    for (int b = 0; b < 15; b++) frameBuf[0][b] = 8'h10 + 8'(b);
    frameLen[0] = 15;
    pushFrame(0);
    streamDone = 1'b0;
    fork
      begin
        applyStimulus(0, -1);
        streamDone = 1'b1;
      end
      begin
        for (int c = 0; c < 400 && !(streamDone && sb.size() == 0); c++) begin
          tx_data_ready = ((c % 10) == 9);
          @(posedge clk);
          #1;
        end
      end
    join
    tx_data_ready = 1'b1;
    waitDrain();

    // Requester 1 stalls mid-frame for 50 cycles while requester 3 waits
    frameBuf[1][0] = 8'h11; frameBuf[1][1] = 8'h12;
    frameBuf[1][2] = 8'h13; frameBuf[1][3] = 8'h14;
    frameLen[1] = 4;
    frameBuf[3][0] = 8'hD1; frameBuf[3][1] = 8'hD2;
    frameLen[3] = 2;
    pushFrame(1);
    pushFrame(3);
    fork
      applyStimulus(1, 2);
      applyStimulus(3, -1);
    join
    waitDrain();

    // Move rr_ptr to 2, then reset in the middle of a frame from requester 2
    frameBuf[1][0] = 8'h5A;
    frameLen[1] = 1;
    pushFrame(1);
    applyStimulus(1, -1);
    waitDrain();
    tx_data_ready = 1'b0;
    reqData[2]  = 8'h77;
    reqLast[2]  = 1'b0;
    reqValid[2] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("preRstValid", 32'(tx_data_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    reqValid[2] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstValid", 32'(tx_data_valid), 32'd0);
    checkOutput("postRstGrant", 32'(grant), 32'd0);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    tx_data_ready = 1'b1;
    frameBuf[1][0] = 8'h61; frameLen[1] = 1;
    frameBuf[3][0] = 8'h63; frameLen[3] = 1;
    pushFrame(1);
    pushFrame(3);
    fork
      applyStimulus(1, -1);
      applyStimulus(3, -1);
    join
    waitDrain();

    // Single-byte frame held at the output while the transmitter stalls
    frameBuf[0][0] = 8'h55;
    frameLen[0] = 1;
    pushFrame(0);
    tx_data_ready = TAG_ON;
    fork
      applyStimulus(0, -1);
      begin
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
          @(negedge clk);
          if (req_ready[0]) got = 1'b1;
        end
        if (!got) checkOutput("accTimeout", 32'd0, 32'd1);
        checkOutput("grantAtAcc", 32'(grant), 32'h1);
        @(posedge clk);
        #1;
        tx_data_ready = 1'b0;
        @(negedge clk);
        checkOutput("grantClr", 32'(grant), 32'd0);
        checkOutput("hold55Valid", 32'(tx_data_valid), 32'd1);
        checkOutput("hold55", 32'(tx_data), 32'h55);
        repeat (4) begin
          @(negedge clk);
          checkOutput("hold55", 32'(tx_data), 32'h55);
        end
      end
    join
    @(posedge clk);
    #1;
    tx_data_ready = 1'b1;
    waitDrain();

    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter TAG_BASE, default 8'h30: tag byte for requester 0; requester i uses TAG_BASE+i.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_data  input  NUM_REQ*8  byte from requester i on bits [i*8+:8].
REQ-006 req_valid  input  NUM_REQ  requester i offers a byte.
REQ-007 req_last  input  NUM_REQ  offered byte is the final byte of its frame.
REQ-008 req_ready  output  NUM_REQ  byte from requester i is accepted this cycle.
REQ-009 tx_data  output  8  byte to the UART transmitter.
REQ-010 tx_data_valid  output  1  tx_data holds a byte for the transmitter.
REQ-011 tx_data_ready  input  1  transmitter accepts tx_data this cycle.
REQ-012 grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
REQ-013 busy  output  1  high whenever the state is not IDLE or tx_data_valid is high.

Function
REQ-014 Handshakes: the output transfer occurs on a cycle where tx_data_valid && tx_data_ready; the input transfer occurs on a cycle where req_valid[i] && req_ready[i].
REQ-015 The output is a single register stage; tx_data_valid is set on load, held with tx_data stable until transfer, then cleared unless reloaded in the same cycle.
REQ-016 "Slot free" is defined as !tx_data_valid || tx_data_ready.
REQ-017 States are IDLE, TAG and DATA.
REQ-018 IDLE: if any req_valid is high, grant the first set bit searching from rr_ptr upward with wrap; the next state is TAG (tag enabled) or DATA.
REQ-019 Grant latency is exactly 1 cycle: grant becomes one-hot on the edge after req_valid is sampled in IDLE.
REQ-020 TAG: when the slot is free, load TAG_BASE+idx into tx_data and go to DATA; req_ready stays 0.
REQ-021 DATA: req_ready[idx] = grant[idx] && req_valid[idx] && slot free (combinational); every other bit of req_ready is 0.
REQ-022 DATA: an accepted byte loads tx_data on the same edge, giving 1-cycle latency from input transfer to tx_data_valid.
REQ-023 DATA: acceptance with req_last set causes grant to clear, the state to go to IDLE and rr_ptr to become (idx+1) mod NUM_REQ, all on that edge.
REQ-024 The grant is locked for the whole frame; req_valid from non-granted requesters is ignored and the grant is not preempted.
REQ-025 If the granted requester deasserts req_valid mid-frame, the grant is held indefinitely (no timeout).
REQ-026 A single-byte frame (req_last on the first byte) is legal.
REQ-027 IDLE costs exactly 1 cycle between frames; the final data byte may still be pending in the output register while IDLE arbitrates.
REQ-028 When all requesters are valid simultaneously, grants rotate strictly in order rr_ptr, rr_ptr+1, and so on.
REQ-029 tx_data_ready is ignored while tx_data_valid is low.
REQ-030 Changes on req_data and req_last while req_ready is low have no effect.

Reset
REQ-031 While rst is high at a clock edge: state=IDLE, grant=0, rr_ptr=0, tx_data=8'h00, tx_data_valid=0, req_ready=0 and busy=0.
REQ-032 Reset mid-frame discards the pending output byte and the partial frame; nothing is transmitted afterwards until a fresh arbitration.

Configuration
REQ-033 The macro UART_ARB_TAG_EN controls the tag feature.
REQ-034 With UART_ARB_TAG_EN defined, each frame is preceded by one tag byte (TAG_BASE+idx) through the TAG state.
REQ-035 Without UART_ARB_TAG_EN, the TAG state and its logic are not compiled, and IDLE goes directly to DATA.

Verification
REQ-036 Tag enabled, tx_data_ready=1: requester 2 sends "OK",0D0A with last on 0A -> output bytes 32,4F,4B,0D,0A; grant=4'b0100 from 1 cycle after req_valid until 0A is accepted.
REQ-037 All 4 requesters send a 1-byte frame 8'hA0+i, with rr_ptr=0 and tag disabled -> output A0,A1,A2,A3; the next frame from requester 0 goes last.
REQ-038 tx_data_ready pulses 1 cycle in 10 while requester 0 streams 15 bytes -> tx_data stays stable while waiting, all 15 bytes arrive in order, nothing is lost or duplicated.
REQ-039 Requester 1 stalls req_valid for 50 cycles mid-frame while requester 3 is valid -> grant stays 4'b0010 and req_ready[3]=0 throughout; requester 3 is served after requester 1's last byte.
REQ-040 rst asserted for 1 cycle while tx_data_valid=1 mid-frame -> next cycle tx_data_valid=0, grant=0, busy=0; the next arbitration starts from requester 0.
REQ-041 Tag disabled, requester 0 sends a single byte 8'h55 with last while tx_data_ready=0 for 5 cycles -> tx_data=55 held for 5 cycles, and grant clears 1 cycle after acceptance.
